bcd_tens_display: RTL and testbench

Downstream stage for the mod-10 T-flip-flop ripple counter. It samples the counter's 4-bit BCD units digit and derives a tens digit from each 9→0 wrap. It then drives a two-digit, time-multiplexed seven-segment display with leading-zero blanking. Sticky flags report tens overflow and illegal (non-BCD) input codes.

---
 rtl/bcd_tens_display.sv | 124 ++++++++++++
 tb/tb_bcd_tens_display.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_tens_display.sv
// Two-digit BCD display stage: synchronizes the ripple-counter units digit, derives
// a tens digit from each 9->0 wrap, and multiplexes both onto one seven-segment port.
module bcd_tens_display #(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [3:0] units_in,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       ovf,
    output logic       err
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [3:0]    r_s1;
    logic [3:0]    r_s2;
    logic [3:0]    r_units;
    logic [3:0]    r_tens;
    logic          r_ovf;
    logic          r_err;
    logic [CW-1:0] r_cnt;
    logic          r_sel;
    logic [6:0]    r_seg;
    logic [1:0]    r_an;

    logic          w_legal;
    logic          w_wrap;
    logic          w_cnt_tc;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg_dec;
    logic [6:0]    w_seg_next;
    logic [1:0]    w_an_next;

    assign w_legal  = (r_s2 <= 4'd9);
    assign w_wrap   = (r_units == 4'd9) && (r_s2 == 4'd0);
    assign w_cnt_tc = (r_cnt == CW'(REFRESH_DIV - 1));

    // Synchronizer runs unconditionally; capture and wrap logic sit behind clr/en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1    <= 4'd0;
            r_s2    <= 4'd0;
            r_units <= 4'd0;
            r_tens  <= 4'd0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_s1 <= units_in;
            r_s2 <= r_s1;
            if (clr) begin
                r_units <= 4'd0;
                r_tens  <= 4'd0;
                r_ovf   <= 1'b0;
                r_err   <= 1'b0;
            end else if (en) begin
                if (w_legal) begin
                    r_units <= r_s2;
                    if (w_wrap) begin
                        if (r_tens == 4'd9) begin
                            r_tens <= 4'd0;
                            r_ovf  <= 1'b1;
                        end else begin
                            r_tens <= r_tens + 4'd1;
                        end
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_digit = r_sel ? r_tens : r_units;
        case (w_digit)
            4'd0:    w_seg_dec = 7'h7E;
            4'd1:    w_seg_dec = 7'h30;
            4'd2:    w_seg_dec = 7'h6D;
            4'd3:    w_seg_dec = 7'h79;
            4'd4:    w_seg_dec = 7'h33;
            4'd5:    w_seg_dec = 7'h5B;
            4'd6:    w_seg_dec = 7'h5F;
            4'd7:    w_seg_dec = 7'h70;
            4'd8:    w_seg_dec = 7'h7F;
            4'd9:    w_seg_dec = 7'h7B;
            default: w_seg_dec = 7'h00;
        endcase
        // A zero tens digit is blanked rather than shown as a leading 0.
        w_seg_next = (r_sel && (r_tens == 4'd0)) ? 7'h00 : w_seg_dec;
        w_an_next  = r_sel ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_sel <= 1'b0;
            r_seg <= 7'h7E;
            r_an  <= 2'b01;
        end else begin
            if (w_cnt_tc) begin
                r_cnt <= '0;
                r_sel <= ~r_sel;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign units = r_units;
    assign tens  = r_tens;
    assign ovf   = r_ovf;
    assign err   = r_err;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule

// File: tb/tb_bcd_tens_display.sv
// Randomized bench for bcd_tens_display: a two-digit count model (0..99) tracks
// every clock edge and all outputs are compared against it after each edge.
module tb_bcd_tens_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] units_in = 4'd0;
    logic [3:0] units;
    logic [3:0] tens;
    logic [6:0] seg;
    logic [1:0] an;
    logic       ovf;
    logic       err;

    int checks = 0;
    int errors = 0;

    bcd_tens_display #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .units_in (units_in),
        .units    (units),
        .tens     (tens),
        .seg      (seg),
        .an       (an),
        .ovf      (ovf),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Reference state: the displayed value as one number, plus the input delay line.
    logic [6:0] seg_tbl [10];
    int         m_total;
    bit         m_ovf;
    bit         m_err;
    int         m_edges;
    logic [3:0] m_dly [2];
    logic [6:0] exp_seg;
    logic [1:0] exp_an;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_total  = 0;
        m_ovf    = 1'b0;
        m_err    = 1'b0;
        m_edges  = 0;
        m_dly[0] = 4'd0;
        m_dly[1] = 4'd0;
        exp_seg  = 7'h7E;
        exp_an   = 2'b01;
    endtask

    task automatic model_step();
        int         u;
        int         t;
        bit         sel_before;
        logic [3:0] cap;
        if (!rst) begin
            model_reset();
            return;
        end
        u          = m_total % 10;
        t          = m_total / 10;
        sel_before = ((m_edges / DIV) % 2) == 1;
        exp_an     = sel_before ? 2'b10 : 2'b01;
        exp_seg    = sel_before ? ((t == 0) ? 7'h00 : seg_tbl[t]) : seg_tbl[u];
        cap        = m_dly[1];
        m_dly[1]   = m_dly[0];
        m_dly[0]   = units_in;
        if (clr) begin
            m_total = 0;
            m_ovf   = 1'b0;
            m_err   = 1'b0;
        end else if (en) begin
            if (cap > 4'd9) begin
                m_err = 1'b1;
            end else if (u == 9 && cap == 4'd0) begin
                if (m_total == 99) m_ovf = 1'b1;
                m_total = (m_total + 1) % 100;
            end else begin
                m_total = m_total - u + int'(cap);
            end
        end
        m_edges++;
    endtask

    task automatic compare_all();
        chk("units", {4'd0, units}, 8'(m_total % 10));
        chk("tens",  {4'd0, tens},  8'(m_total / 10));
        chk("ovf",   {7'd0, ovf},   {7'd0, m_ovf});
        chk("err",   {7'd0, err},   {7'd0, m_err});
        chk("seg",   {1'b0, seg},   {1'b0, exp_seg});
        chk("an",    {6'd0, an},    {6'd0, exp_an});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic hold(input logic [3:0] d, input int n);
        units_in = d;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic count_to(input int reps, input int last);
        for (int r = 0; r < reps; r++)
            for (int d = 1; d <= 10; d++) hold(4'(d % 10), $urandom_range(5, 3));
        for (int d = 1; d <= last; d++) hold(4'(d), 3);
    endtask

    initial begin
        seg_tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
        model_reset();

        // Reset values, then refresh toggling with tens blanked.
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        $display("reset/refresh done: an=%b seg=%h", an, seg);

        // Single wrap 0..9 then 0.
        en = 1'b1;
        for (int d = 0; d <= 10; d++) hold(4'(d % 10), 5);
        hold(4'd0, 2 * DIV);
        $display("single wrap: tens=%0d units=%0d", tens, units);

        // 100 full sequences: tens overflows, then clear.
        count_to(100, 0);
        $display("overflow run: tens=%0d ovf=%b", tens, ovf);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        hold(4'd0, 3);
        $display("clear: ovf=%b tens=%0d units=%0d", ovf, tens, units);

        // Illegal code with units=5, then a legal 6.
        hold(4'd5, 5);
        hold(4'hC, 5);
        hold(4'd6, 5);
        $display("illegal code: err=%b units=%0d", err, units);

        // Enable low holds digits while the input moves.
        en = 1'b0;
        for (int i = 0; i < 6; i++) hold(4'($urandom_range(9, 0)), 3);
        en = 1'b1;
        hold(4'd9, 4);

        // clr coincides with the 9->0 capture edge.
        units_in = 4'd0;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        hold(4'd0, 3);
        $display("clr on wrap: tens=%0d ovf=%b", tens, ovf);

        // Reach tens=3, units=7, then drop reset between edges.
        count_to(3, 7);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        $display("async reset: units=%0d tens=%0d an=%b seg=%h", units, tens, an, seg);
        tick();
        rst = 1'b1;
        hold(4'd7, 4);
        count_to(1, 4);

        // Random traffic with occasional glitch codes, enable drops and clears.
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(9, 0) != 0);
            clr = ($urandom_range(39, 0) == 0);
            if ($urandom_range(19, 0) == 0) units_in = 4'($urandom_range(15, 10));
            else                            units_in = 4'($urandom_range(9, 0));
            tick();
        end
        clr = 1'b0;
        $display("random phase: tens=%0d units=%0d ovf=%b err=%b", tens, units, ovf, err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
